// File: rtl/xmt_fifo_ser.sv
// -----------------------------------------------------------------------------
// xmt_fifo_ser
//
// Transmit side of the debug/back-channel serial port. Bytes written by the
// bus-facing register block are queued in a circular FIFO and shifted out on
// txd as 8N1 frames (start bit, 8 data bits LSB first, stop bit), each line
// bit lasting CLK_DIV clock cycles. Consecutive queued bytes are sent with no
// idle gap between the stop bit of one frame and the start bit of the next.
//
// Parameters
//   CLK_DIV     clock cycles per serial bit (>= 2)
//   DEPTH_LOG2  log2 of the FIFO depth
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   wr       write strobe, data_in is enqueued when rdy is high
//   data_in  byte to transmit
//   rdy      FIFO not full (a write this cycle is accepted)
//   level    bytes queued, not counting the byte on the line
//   busy     a frame is being transmitted
//   txd      registered serial output, idles high
// -----------------------------------------------------------------------------
module xmt_fifo_ser #(
    parameter int CLK_DIV    = 434,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [7:0]            data_in,
    output logic                  rdy,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  busy,
    output logic                  txd
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(CLK_DIV);

    localparam logic [CNT_W-1:0]    DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;

    // Serializer state
    state_t                state_q,   state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q,   shift_d;
    logic                  txd_q,     txd_d;

    logic                  push;
    logic                  pop;
    logic [7:0]            head;

    assign rdy   = (count_q != COUNT_FULL);
    assign level = count_q;
    assign busy  = (state_q != S_IDLE);
    assign txd   = txd_q;

    assign push  = wr && rdy;
    assign head  = mem_q[rd_ptr_q];

    // Serializer next-state. txd_d is the value the line takes in the state
    // being entered, so the line changes on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (count_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = head;
                    bit_cnt_d = DIV_LAST;
                    state_d   = S_START;
                    txd_d     = 1'b0;
                end
            end

            S_START: begin
                if (bit_cnt_q == '0) begin
                    bit_cnt_d = DIV_LAST;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                    txd_d     = shift_q[0];
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end

            S_DATA: begin
                if (bit_cnt_q == '0) begin
                    bit_cnt_d = DIV_LAST;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        // next bit is what shift[0] becomes after the shift
                        txd_d     = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end

            S_STOP: begin
                if (bit_cnt_q == '0) begin
                    if (count_q != '0) begin
                        // chain straight into the next start bit
                        pop       = 1'b1;
                        shift_d   = head;
                        bit_cnt_d = DIV_LAST;
                        state_d   = S_START;
                        txd_d     = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // FIFO pointer/count next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage has no reset; stale entries are never read because count
    // gates every pop.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_xmt_fifo_ser.sv
// -----------------------------------------------------------------------------
// tb_xmt_fifo_ser
//
// Directed bench for xmt_fifo_ser with CLK_DIV=4 and a 16-entry FIFO. A line
// receiver decodes txd into a byte queue plus start-bit timestamps; the main
// initial block drives writes and compares against hand-derived values.
// -----------------------------------------------------------------------------
module tb_xmt_fifo_ser;

    localparam int DIV = 4;
    localparam int DL2 = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr = 1'b0;
    logic [7:0]   data_in = 8'h00;
    logic         rdy;
    logic [DL2:0] level;
    logic         busy;
    logic         txd;

    int checks = 0;
    int errors = 0;

    xmt_fifo_ser #(
        .CLK_DIV    (DIV),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr),
        .data_in (data_in),
        .rdy     (rdy),
        .level   (level),
        .busy    (busy),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    // ---------------- line receiver ----------------
    int         cyc = 0;
    logic       rx_active;
    int         rx_cnt;
    logic [7:0] rx_byte;
    int         frame_err = 0;
    logic [7:0] rx_q[$];
    int         rx_start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // rx_cnt counts negedges since the start bit was first seen; each bit
    // is sampled in the middle of its DIV-cycle window.
    always @(negedge clk) begin
        if (rst) begin
            rx_active <= 1'b0;
            rx_cnt    <= 0;
            rx_byte   <= 8'h00;
        end else if (!rx_active) begin
            if (txd == 1'b0) begin
                rx_active <= 1'b1;
                rx_cnt    <= 1;
                rx_start_q.push_back(cyc);
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if ((rx_cnt % DIV) == DIV / 2 && (rx_cnt / DIV) >= 1 && (rx_cnt / DIV) <= 8)
                rx_byte[(rx_cnt / DIV) - 1] <= txd;
            if (rx_cnt == 9 * DIV + DIV / 2) begin
                if (txd !== 1'b1) frame_err <= frame_err + 1;
                rx_q.push_back(rx_byte);
                rx_active <= 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    function automatic logic [7:0] wrap_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int         rb;
        int         sb;
        int         sent;
        int         n;
        int         max_lvl;
        logic       bad_line;
        logic [7:0] b;
        logic       exp_bit;

        // --- reset state ---
        rst = 1'b1;
        tick();
        tick();
        chk("reset_txd",   32'(txd),   32'd1);
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_rdy",   32'(rdy),   32'd1);
        rst = 1'b0;
        tick();
        tick();

        // --- single byte 0x55 ---
        rb = rx_q.size();
        b  = 8'h55;
        wr = 1'b1; data_in = b;
        tick();                                    // edge E
        wr = 1'b0;
        chk("single_level_E",  32'(level), 32'd1);
        chk("single_txd_E",    32'(txd),   32'd1);
        chk("single_busy_E",   32'(busy),  32'd0);
        tick();                                    // edge E+1
        chk("single_level_E1", 32'(level), 32'd0);
        for (int k = 0; k < 10 * DIV; k++) begin
            if (k < DIV)             exp_bit = 1'b0;
            else if (k >= 9 * DIV)   exp_bit = 1'b1;
            else                     exp_bit = b[(k / DIV) - 1];
            chk($sformatf("single_txd_k%0d", k), 32'(txd),  32'(exp_bit));
            chk($sformatf("single_busy_k%0d", k), 32'(busy), 32'd1);
            tick();
        end
        chk("single_busy_end", 32'(busy), 32'd0);
        chk("single_rx_count", 32'(rx_q.size() - rb), 32'd1);
        if (rx_q.size() > rb) chk("single_rx_byte", 32'(rx_q[rb]), 32'h55);

        // --- back-to-back 0x00, 0xFF ---
        tick();
        rb = rx_q.size();
        sb = rx_start_q.size();
        wr = 1'b1; data_in = 8'h00;
        tick();                                    // E
        chk("b2b_level_E",  32'(level), 32'd1);
        data_in = 8'hFF;
        tick();                                    // E+1: pop + write
        wr = 1'b0;
        chk("b2b_level_E1", 32'(level), 32'd1);
        chk("b2b_txd_E1",   32'(txd),   32'd0);
        repeat (10 * DIV - 1) tick();              // E+40: last stop cycle
        chk("b2b_level_E40", 32'(level), 32'd1);
        chk("b2b_txd_E40",   32'(txd),   32'd1);
        tick();                                    // E+41: second start bit
        chk("b2b_level_E41", 32'(level), 32'd0);
        chk("b2b_txd_E41",   32'(txd),   32'd0);
        chk("b2b_busy_E41",  32'(busy),  32'd1);
        wait_idle("b2b_idle_timeout", 200);
        chk("b2b_rx_count", 32'(rx_q.size() - rb), 32'd2);
        if (rx_q.size() >= rb + 2) begin
            chk("b2b_rx_byte0", 32'(rx_q[rb]),     32'h00);
            chk("b2b_rx_byte1", 32'(rx_q[rb + 1]), 32'hFF);
        end
        if (rx_start_q.size() >= sb + 2)
            chk("b2b_start_gap", 32'(rx_start_q[sb + 1] - rx_start_q[sb]), 32'd40);
        else
            chk("b2b_start_count", 32'(rx_start_q.size() - sb), 32'd2);

        // --- reset mid-frame (0xA5 at bit 3, 0x3C still queued) ---
        tick();
        wr = 1'b1; data_in = 8'hA5;
        tick();                                    // E
        data_in = 8'h3C;
        tick();                                    // E+1
        wr = 1'b0;
        repeat (17) tick();                        // E+18: inside data bit 3
        chk("midrst_pre_busy",  32'(busy),  32'd1);
        chk("midrst_pre_txd",   32'(txd),   32'd0);    // 0xA5 bit 3 = 0
        chk("midrst_pre_level", 32'(level), 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst_txd",   32'(txd),   32'd1);
        chk("midrst_busy",  32'(busy),  32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_rdy",   32'(rdy),   32'd1);
        rst = 1'b0;
        rb = rx_q.size();
        bad_line = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (txd !== 1'b1 || busy !== 1'b0) bad_line = 1'b1;
        end
        chk("midrst_quiet_line", 32'(bad_line), 32'd0);
        chk("midrst_no_rx",      32'(rx_q.size() - rb), 32'd0);

        // --- full FIFO: 0xEE on the line, then 0x00..0x0F, then 0x10 dropped ---
        rb = rx_q.size();
        wr = 1'b1; data_in = 8'hEE;
        tick();
        wr = 1'b0;
        tick();                                    // 0xEE popped, line busy
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; data_in = 8'(i);
            tick();
            if (i == 14) chk("full_rdy_at15", 32'(rdy), 32'd1);
        end
        chk("full_level16", 32'(level), 32'd16);
        chk("full_rdy_low", 32'(rdy),   32'd0);
        data_in = 8'h10;
        tick();
        wr = 1'b0;
        chk("full_drop_level", 32'(level), 32'd16);
        wait_idle("full_idle_timeout", 1000);
        chk("full_rx_count", 32'(rx_q.size() - rb), 32'd17);
        if (rx_q.size() >= rb + 17) begin
            chk("full_rx_first", 32'(rx_q[rb]), 32'hEE);
            for (int i = 0; i < 16; i++)
                chk($sformatf("full_rx_%0d", i), 32'(rx_q[rb + 1 + i]), 32'(i));
        end

        // --- simultaneous write and pop at count 16 ---
        tick();
        rb = rx_q.size();
        wr = 1'b1; data_in = 8'h80;
        tick();
        wr = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; data_in = 8'(8'h20 + i);
            tick();
        end
        chk("simul_level16", 32'(level), 32'd16);
        data_in = 8'h30;                            // wr stays high
        n = 0;
        while (!rdy && n < 100) begin
            tick();
            n++;
        end
        chk("simul_rdy_rise",  32'(rdy),   32'd1);
        chk("simul_level15",   32'(level), 32'd15);
        tick();                                    // held write accepted here
        wr = 1'b0;
        chk("simul_level_back16", 32'(level), 32'd16);
        chk("simul_rdy_low",      32'(rdy),   32'd0);
        wait_idle("simul_idle_timeout", 1200);
        chk("simul_rx_count", 32'(rx_q.size() - rb), 32'd18);
        if (rx_q.size() >= rb + 18) begin
            chk("simul_rx_first", 32'(rx_q[rb]), 32'h80);
            for (int i = 0; i < 16; i++)
                chk($sformatf("simul_rx_%0d", i), 32'(rx_q[rb + 1 + i]), 32'(8'h20 + i));
            chk("simul_rx_last", 32'(rx_q[rb + 17]), 32'h30);
        end

        // --- wrap-around: 40 bytes gated by rdy ---
        tick();
        rb = rx_q.size();
        sent = 0;
        max_lvl = 0;
        n = 0;
        while (sent < 40 && n < 3000) begin
            if (rdy) begin
                wr = 1'b1; data_in = wrap_byte(sent);
                sent++;
            end else begin
                wr = 1'b0;
            end
            tick();
            if (int'(level) > max_lvl) max_lvl = int'(level);
            n++;
        end
        wr = 1'b0;
        chk("wrap_all_sent", 32'(sent), 32'd40);
        wait_idle("wrap_idle_timeout", 2500);
        chk("wrap_max_level", 32'(max_lvl), 32'd16);
        chk("wrap_rx_count", 32'(rx_q.size() - rb), 32'd40);
        if (rx_q.size() >= rb + 40) begin
            for (int i = 0; i < 40; i++)
                chk($sformatf("wrap_rx_%0d", i), 32'(rx_q[rb + i]), 32'(wrap_byte(i)));
        end
        chk("stop_bit_errors", 32'(frame_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
